// File: rtl/axis_pkt_demux.sv
// axis_pkt_demux: routes AXI-Stream packets from one slave port to one of
// NUM_CH master ports. The channel is chosen by bus_sel on the first beat
// of each packet and held for the rest of that packet. A 2-entry buffer
// sits between input and outputs and preserves beat order across channel
// switches.
//
// Optional feature: define AXIS_PKT_DEMUX_DROP_EN to accept packets with an
// invalid start-of-packet select and discard them. This also adds a
// saturating drop_cnt output. When the macro is undefined, an invalid
// select holds the input off instead.
module axis_pkt_demux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   bus_sel,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [NUM_CH*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]            m_axis_tvalid,
    output logic [NUM_CH-1:0]            m_axis_tlast,
    input  logic [NUM_CH-1:0]            m_axis_tready,
    output logic                         busy
`ifdef AXIS_PKT_DEMUX_DROP_EN
    ,
    output logic [15:0]                  drop_cnt
`endif
);

    localparam int TW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {
        ST_SOP = 1'b0,
        ST_MID = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic                  last_q [2];
    logic                  last_d [2];
    logic [TW-1:0]         idx_q  [2];
    logic [TW-1:0]         idx_d  [2];
    logic                  drop_q [2];
    logic                  drop_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  rdy_q, rdy_d;
    logic [TW-1:0]         tag_idx_q, tag_idx_d;
    logic                  tag_drop_q, tag_drop_d;

    logic                  sel_ok_s;
    logic [TW-1:0]         sel_idx_s;
    logic                  sop_drop_s;
    logic [TW-1:0]         pkt_idx_s;
    logic                  pkt_drop_s;
    logic                  s_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_valid_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  head_last_s;
    logic [TW-1:0]         head_idx_s;
    logic                  head_drop_s;
    logic [NUM_CH-1:0]     m_valid_s;

    // Decode the select, build the packet tag and the input/output handshakes.
    always_comb begin
        sel_ok_s  = bus_sel[7] && (bus_sel[6:0] < 7'(NUM_CH));
        sel_idx_s = bus_sel[TW-1:0];
`ifdef AXIS_PKT_DEMUX_DROP_EN
        sop_drop_s = !sel_ok_s;
        s_ready_s  = rdy_q;
`else
        sop_drop_s = 1'b0;
        s_ready_s  = rdy_q && ((state_q == ST_MID) || sel_ok_s);
`endif
        if (state_q == ST_SOP) begin
            pkt_idx_s  = sel_idx_s;
            pkt_drop_s = sop_drop_s;
        end else begin
            pkt_idx_s  = tag_idx_q;
            pkt_drop_s = tag_drop_q;
        end
        push_s       = s_axis_tvalid && s_ready_s;
        head_valid_s = (count_q != 2'd0);
        head_data_s  = data_q[rd_ptr_q];
        head_last_s  = last_q[rd_ptr_q];
        head_idx_s   = idx_q[rd_ptr_q];
        head_drop_s  = drop_q[rd_ptr_q];
        pop_s        = head_valid_s && (head_drop_s || m_axis_tready[head_idx_s]);
    end

    // Per-channel valid: only the channel named by the head tag, never for dropped beats.
    always_comb begin
        m_valid_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_valid_s[k] = head_valid_s && !head_drop_s && (head_idx_s == TW'(k));
        end
    end

    // Next state for the input FSM, packet tag, buffer entries, pointers and ready.
    always_comb begin
        state_d    = state_q;
        tag_idx_d  = tag_idx_q;
        tag_drop_d = tag_drop_q;
        data_d     = data_q;
        last_d     = last_q;
        idx_d      = idx_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            data_d[wr_ptr_q] = s_axis_tdata;
            last_d[wr_ptr_q] = s_axis_tlast;
            idx_d[wr_ptr_q]  = pkt_idx_s;
            drop_d[wr_ptr_q] = pkt_drop_s;
            wr_ptr_d         = ~wr_ptr_q;
            tag_idx_d        = pkt_idx_s;
            tag_drop_d       = pkt_drop_s;
            if (s_axis_tlast) begin
                state_d = ST_SOP;
            end else begin
                state_d = ST_MID;
            end
        end else begin
            state_d = state_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Ready is registered: it reflects the occupancy after this edge.
        rdy_d = (count_d != 2'd2);
    end

    // State and buffer registers; reset empties the buffer and discards any open packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SOP;
            tag_idx_q  <= '0;
            tag_drop_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            rdy_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
                idx_q[i]  <= '0;
                drop_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            tag_idx_q  <= tag_idx_d;
            tag_drop_q <= tag_drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                last_q[i] <= last_d[i];
                idx_q[i]  <= idx_d[i];
                drop_q[i] <= drop_d[i];
            end
        end
    end

`ifdef AXIS_PKT_DEMUX_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Count dropped packets on the pop of their last beat, saturating at all-ones.
    always_comb begin
        if (pop_s && head_drop_s && head_last_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = {NUM_CH{head_data_s}};
    assign m_axis_tvalid = m_valid_s;
    assign m_axis_tlast  = m_valid_s & {NUM_CH{head_last_s}};
    assign busy          = (state_q == ST_MID) || (count_q != 2'd0);

endmodule

// File: tb/tb_axis_pkt_demux.sv
// Directed testbench for axis_pkt_demux (NUM_CH=4, DATA_WIDTH=32).
// The main vectors come from a per-cycle table. Backpressure, reset in the
// middle of a packet and (with AXIS_PKT_DEMUX_DROP_EN) packet dropping are
// covered by hand-written sequences.
module tb_axis_pkt_demux;

    localparam int DW = 32;
    localparam int NC = 4;

    logic             clk;
    logic             rst;
    logic [7:0]       bus_sel;
    logic [DW-1:0]    s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tlast;
    logic             s_axis_tready;
    logic [NC*DW-1:0] m_axis_tdata;
    logic [NC-1:0]    m_axis_tvalid;
    logic [NC-1:0]    m_axis_tlast;
    logic [NC-1:0]    m_axis_tready;
    logic             busy;
`ifdef AXIS_PKT_DEMUX_DROP_EN
    logic [15:0]      drop_cnt;
`endif

    int total;
    int bad;

    axis_pkt_demux #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus_sel       (bus_sel),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy)
`ifdef AXIS_PKT_DEMUX_DROP_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sel;
        logic        tv;
        logic [31:0] td;
        logic        tl;
        logic [3:0]  mrdy;
        logic        e_srdy;
        logic [3:0]  e_mv;
        logic [3:0]  e_ml;
        logic [31:0] e_d;
        logic        e_busy;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic [7:0] sel, input logic tv, input logic [31:0] td,
                                input logic tl, input logic [3:0] mrdy, input logic e_srdy,
                                input logic [3:0] e_mv, input logic [3:0] e_ml,
                                input logic [31:0] e_d, input logic e_busy);
        vec_t v;
        v.sel = sel; v.tv = tv; v.td = td; v.tl = tl; v.mrdy = mrdy;
        v.e_srdy = e_srdy; v.e_mv = e_mv; v.e_ml = e_ml; v.e_d = e_d; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus_sel       = 8'h00;
        s_axis_tdata  = 32'h0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 4'hF;

        // Cycle table: inputs for one cycle plus the outputs expected during it.
        vecs[0]  = mk(8'h82, 1'b1, 32'hA000_0001, 1'b0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,          1'b0);
        vecs[1]  = mk(8'h82, 1'b1, 32'hA000_0002, 1'b0, 4'hF, 1'b1, 4'h4, 4'h0, 32'hA000_0001, 1'b1);
        vecs[2]  = mk(8'h82, 1'b1, 32'hA000_0003, 1'b1, 4'hF, 1'b1, 4'h4, 4'h0, 32'hA000_0002, 1'b1);
        vecs[3]  = mk(8'h81, 1'b1, 32'hB000_0001, 1'b0, 4'hF, 1'b1, 4'h4, 4'h4, 32'hA000_0003, 1'b1);
        vecs[4]  = mk(8'h83, 1'b1, 32'hB000_0002, 1'b0, 4'hF, 1'b1, 4'h2, 4'h0, 32'hB000_0001, 1'b1);
        vecs[5]  = mk(8'h83, 1'b1, 32'hB000_0003, 1'b1, 4'hF, 1'b1, 4'h2, 4'h0, 32'hB000_0002, 1'b1);
        vecs[6]  = mk(8'h83, 1'b1, 32'hC000_0001, 1'b1, 4'hF, 1'b1, 4'h2, 4'h2, 32'hB000_0003, 1'b1);
        vecs[7]  = mk(8'h00, 1'b1, 32'hD000_0001, 1'b0, 4'hF, 1'b0, 4'h8, 4'h8, 32'hC000_0001, 1'b1);
        vecs[8]  = mk(8'h00, 1'b1, 32'hD000_0001, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,          1'b0);
        vecs[9]  = mk(8'h84, 1'b1, 32'hD000_0001, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,          1'b0);
        vecs[10] = mk(8'h80, 1'b1, 32'hD000_0001, 1'b0, 4'hF, 1'b1, 4'h0, 4'h0, 32'h0,          1'b0);
        vecs[11] = mk(8'h00, 1'b1, 32'hD000_0002, 1'b1, 4'hF, 1'b1, 4'h1, 4'h0, 32'hD000_0001, 1'b1);
        vecs[12] = mk(8'h00, 1'b0, 32'h0,          1'b0, 4'hF, 1'b0, 4'h1, 4'h1, 32'hD000_0002, 1'b1);
        vecs[13] = mk(8'h00, 1'b0, 32'h0,          1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 32'h0,          1'b0);

        // Outputs while reset is held.
        #12;
        chk("rst srdy",  64'(s_axis_tready), 64'h0);
        chk("rst mvalid", 64'(m_axis_tvalid), 64'h0);
        chk("rst mlast", 64'(m_axis_tlast), 64'h0);
        chk("rst mdata", 64'(m_axis_tdata[63:0]), 64'h0);
        chk("rst busy",  64'(busy), 64'h0);
        bus_sel = 8'h82;
        #1 rst = 1'b0;
        #1;
        chk("ready before first edge", 64'(s_axis_tready), 64'h0);
        @(posedge clk); #1;
        chk("ready after first edge", 64'(s_axis_tready), 64'h1);

        // Table-driven main sequence.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            bus_sel       = vecs[i].sel;
            s_axis_tvalid = vecs[i].tv;
            s_axis_tdata  = vecs[i].td;
            s_axis_tlast  = vecs[i].tl;
            m_axis_tready = vecs[i].mrdy;
            #3;
            chk($sformatf("v%0d srdy", i),   64'(s_axis_tready), 64'(vecs[i].e_srdy));
            chk($sformatf("v%0d mvalid", i), 64'(m_axis_tvalid), 64'(vecs[i].e_mv));
            chk($sformatf("v%0d mlast", i),  64'(m_axis_tlast),  64'(vecs[i].e_ml));
            chk($sformatf("v%0d busy", i),   64'(busy),          64'(vecs[i].e_busy));
            for (int k = 0; k < NC; k++) begin
                if (vecs[i].e_mv[k]) begin
                    chk($sformatf("v%0d data ch%0d", i, k), 64'(m_axis_tdata[k*DW +: DW]), 64'(vecs[i].e_d));
                end
            end
        end

        // Backpressure on channel 0 for 5 cycles during a 6-beat packet.
        begin
            int si;
            int ri;
            si = 0;
            ri = 0;
            for (int c = 0; c < 40 && ri < 6; c++) begin
                @(posedge clk); #1;
                bus_sel       = 8'h80;
                s_axis_tvalid = (si < 6);
                s_axis_tdata  = 32'hE000_0000 + 32'(si);
                s_axis_tlast  = (si == 5);
                m_axis_tready = (c >= 1 && c <= 5) ? 4'h0 : 4'h1;
                #3;
                if (c == 2 || c == 5) chk($sformatf("bp c%0d srdy low", c), 64'(s_axis_tready), 64'h0);
                if (c == 7) chk("bp c7 srdy high", 64'(s_axis_tready), 64'h1);
                chk($sformatf("bp c%0d other ch", c), 64'(m_axis_tvalid & 4'hE), 64'h0);
                if (s_axis_tvalid && s_axis_tready) si++;
                if (m_axis_tvalid[0] && m_axis_tready[0]) begin
                    chk($sformatf("bp beat%0d data", ri), 64'(m_axis_tdata[DW-1:0]), 64'(32'hE000_0000 + 32'(ri)));
                    chk($sformatf("bp beat%0d last", ri), 64'(m_axis_tlast[0]), 64'(ri == 5));
                    ri++;
                end
            end
            chk("bp beats received", 64'(ri), 64'd6);
            s_axis_tvalid = 1'b0;
        end

`ifdef AXIS_PKT_DEMUX_DROP_EN
        // Packet with out-of-range select is consumed at full rate and counted.
        @(posedge clk); #1;
        m_axis_tready = 4'h0;
        #3;
        chk("drop cnt start", 64'(drop_cnt), 64'h0);
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            bus_sel       = 8'h85;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hF000_0000 + 32'(b);
            s_axis_tlast  = (b == 3);
            #3;
            chk($sformatf("drop b%0d srdy", b), 64'(s_axis_tready), 64'h1);
            chk($sformatf("drop b%0d mvalid", b), 64'(m_axis_tvalid), 64'h0);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        #3;
        chk("drop tail mvalid", 64'(m_axis_tvalid), 64'h0);
        @(posedge clk); #3;
        chk("drop cnt end", 64'(drop_cnt), 64'h1);
        chk("drop busy end", 64'(busy), 64'h0);
`endif

        // Reset asserted with two buffered beats of an open packet.
        @(posedge clk); #1;
        m_axis_tready = 4'h0;
        bus_sel       = 8'h81;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h5100_0000;
        s_axis_tlast  = 1'b0;
        @(posedge clk); #1;
        s_axis_tdata  = 32'h5100_0001;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("pre-rst mvalid", 64'(m_axis_tvalid), 64'h2);
        chk("pre-rst srdy", 64'(s_axis_tready), 64'h0);
        rst = 1'b1;
        #1;
        chk("mid rst srdy",  64'(s_axis_tready), 64'h0);
        chk("mid rst mvalid", 64'(m_axis_tvalid), 64'h0);
        chk("mid rst mlast", 64'(m_axis_tlast), 64'h0);
        chk("mid rst mdata", 64'(m_axis_tdata[63:0]), 64'h0);
        chk("mid rst busy",  64'(busy), 64'h0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus_sel       = 8'h83;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h6300_0000;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 4'hF;
        @(posedge clk); #1;
        chk("post rst srdy", 64'(s_axis_tready), 64'h1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        #2;
        chk("post rst mvalid", 64'(m_axis_tvalid), 64'h8);
        chk("post rst mlast", 64'(m_axis_tlast), 64'h8);
        chk("post rst data", 64'(m_axis_tdata[3*DW +: DW]), 64'h6300_0000);
        @(posedge clk); #3;
        chk("post rst idle mvalid", 64'(m_axis_tvalid), 64'h0);
        chk("post rst idle busy", 64'(busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
